// File: rtl/instr_fetch_reg_if.sv
// Instruction-memory fetch bus: request/address out, one-cycle ack with data back.
interface instr_fetch_reg_if #(
  parameter int IW = 16,
  parameter int AW = 16
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [IW-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_fetch_reg.sv
// Instruction fetch handshake controller + instruction register.
// Issues a fetch on command, captures the returned word and holds it until the
// control unit consumes it. The I-type fields are sliced straight off ir.
// Optional macro FETCH_TIMEOUT_EN: abort a request left unacked for TIMEOUT cycles.
module instr_fetch_reg #(
  parameter int IW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_start,
  input  logic [AW-1:0] pc,
  input  logic          instr_consume,
  input  logic          flush,
  instr_fetch_reg_if.master bus,
  output logic [IW-1:0] ir,
  output logic          instr_valid,
  output logic          busy,
  output logic [3:0]    opcode,
  output logic          m,
  output logic [2:0]    rd_f,
  output logic [2:0]    rs1_f,
  output logic [4:0]    imm_f,
  output logic [15:0]   fetch_count,
  output logic          fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t state, state_d;
  logic   ld_addr;   // latch pc and launch a request
  logic   capture;   // accept the returned word
  logic   abort;     // request timed out
  logic   tmo_hit;

  // The 5-bit timeout counter can only express TIMEOUT in 1..31.
  if (TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_timeout
    $error("instr_fetch_reg: TIMEOUT must be in 1..31");
  end

  // Request and valid are pure functions of state, so reset drops them at once.
  assign bus.mem_req = (state == S_REQ);
  assign instr_valid = (state == S_HOLD);
  assign busy        = (state != S_IDLE);

  assign opcode = ir[15:12];
  assign m      = ir[11];
  assign rd_f   = ir[10:8];
  assign rs1_f  = ir[7:5];
  assign imm_f  = ir[4:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state and datapath strobes; flush overrides everything
  always_comb begin
    state_d = state;
    ld_addr = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (fetch_start) begin
          state_d = S_REQ;
          ld_addr = 1'b1;
        end
        S_REQ: if (bus.mem_ack) begin
          state_d = S_HOLD;
          capture = 1'b1;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          abort   = 1'b1;
        end
        S_HOLD: if (instr_consume) begin
          if (fetch_start) begin
            state_d = S_REQ;
            ld_addr = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Address, instruction register and completed-fetch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_addr <= '0;
      ir           <= '0;
      fetch_count  <= '0;
    end else begin
      if (ld_addr) bus.mem_addr <= pc;
      if (capture) begin
        ir          <= bus.mem_rdata;
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);
  logic [4:0] tmo_cnt;

  // Abort fires on the edge where the count would reach TIMEOUT; an ack then wins.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Timeout counter and one-cycle error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= abort;
      if (flush || ld_addr)                  tmo_cnt <= '0;
      else if (state == S_REQ && !bus.mem_ack) tmo_cnt <= tmo_cnt + 5'd1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Self-checking bench for instr_fetch_reg: directed scenarios plus a random
// run checked against a fetch/hold behavioural model.
module tb_instr_fetch_reg;
  localparam int IW = 16, AW = 16, TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_start, instr_consume, flush;
  logic [AW-1:0] pc;
  logic [IW-1:0] ir;
  logic          instr_valid, busy, m, fetch_err;
  logic [3:0]    opcode;
  logic [2:0]    rd_f, rs1_f;
  logic [4:0]    imm_f;
  logic [15:0]   fetch_count;

  int tests = 0;
  int fails = 0;

  instr_fetch_reg_if #(.IW(IW), .AW(AW)) bus ();

  instr_fetch_reg #(.IW(IW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc(pc),
    .instr_consume(instr_consume), .flush(flush), .bus(bus),
    .ir(ir), .instr_valid(instr_valid), .busy(busy), .opcode(opcode), .m(m),
    .rd_f(rd_f), .rs1_f(rs1_f), .imm_f(imm_f), .fetch_count(fetch_count),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_start = 0; instr_consume = 0; flush = 0; pc = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    tests++;
    if ({bus.mem_req, bus.mem_addr, ir, instr_valid, busy, fetch_count, fetch_err} !== '0) begin
      fails++;
      $display("FAIL reset: req=%b addr=%h ir=%h valid=%b busy=%b cnt=%h err=%b, required all 0",
               bus.mem_req, bus.mem_addr, ir, instr_valid, busy, fetch_count, fetch_err);
    end
    tests++;
    if ({opcode, m, rd_f, rs1_f, imm_f} !== 16'h0) begin
      fails++;
      $display("FAIL reset_fields: %h %b %h %h %h, required 0", opcode, m, rd_f, rs1_f, imm_f);
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_fetch();
    fetch_start = 1; pc = 16'h0010;
    tick();
    fetch_start = 0; pc = '0;
    tests++;
    if (bus.mem_req !== 1 || bus.mem_addr !== 16'h0010 || busy !== 1) begin
      fails++;
      $display("FAIL fetch_req: req=%b addr=%h busy=%b, required 1 0010 1", bus.mem_req, bus.mem_addr, busy);
    end
    bus.mem_ack = 1; bus.mem_rdata = 16'hA9A5;
    tick();
    bus.mem_ack = 0; bus.mem_rdata = '0;
    tests++;
    if (ir !== 16'hA9A5 || instr_valid !== 1 || fetch_count !== 16'd1 || bus.mem_req !== 0) begin
      fails++;
      $display("FAIL fetch_capture: ir=%h valid=%b cnt=%0d req=%b, required a9a5 1 1 0",
               ir, instr_valid, fetch_count, bus.mem_req);
    end
    tests++;
    if (opcode !== 4'hA || m !== 1 || rd_f !== 3'd1 || rs1_f !== 3'd5 || imm_f !== 5'd5) begin
      fails++;
      $display("FAIL fetch_fields: op=%h m=%b rd=%0d rs1=%0d imm=%0d, required a 1 1 5 5",
               opcode, m, rd_f, rs1_f, imm_f);
    end
  endtask

  task automatic test_back_to_back();
    instr_consume = 1; fetch_start = 1; pc = 16'h0012;
    tick();
    instr_consume = 0; fetch_start = 0; pc = '0;
    tests++;
    if (instr_valid !== 0 || bus.mem_req !== 1 || bus.mem_addr !== 16'h0012 || ir !== 16'hA9A5) begin
      fails++;
      $display("FAIL b2b_req: valid=%b req=%b addr=%h ir=%h, required 0 1 0012 a9a5",
               instr_valid, bus.mem_req, bus.mem_addr, ir);
    end
    bus.mem_ack = 1; bus.mem_rdata = 16'h1234;
    tick();
    bus.mem_ack = 0;
    tests++;
    if (ir !== 16'h1234 || fetch_count !== 16'd2 || instr_valid !== 1) begin
      fails++;
      $display("FAIL b2b_capture: ir=%h cnt=%0d valid=%b, required 1234 2 1", ir, fetch_count, instr_valid);
    end
  endtask

  task automatic test_spurious_ack();
    fetch_start = 1; pc = 16'h0044;            // ignored in HOLD without consume
    bus.mem_ack = 1; bus.mem_rdata = 16'hFFFF;
    tick();
    fetch_start = 0; bus.mem_ack = 0;
    tests++;
    if (ir !== 16'h1234 || fetch_count !== 16'd2 || instr_valid !== 1 || bus.mem_req !== 0) begin
      fails++;
      $display("FAIL spurious_hold: ir=%h cnt=%0d valid=%b req=%b, required 1234 2 1 0",
               ir, fetch_count, instr_valid, bus.mem_req);
    end
    instr_consume = 1;
    tick();
    instr_consume = 0;
    bus.mem_ack = 1;
    tick();
    bus.mem_ack = 0;
    tests++;
    if (ir !== 16'h1234 || fetch_count !== 16'd2 || busy !== 0 || instr_valid !== 0) begin
      fails++;
      $display("FAIL spurious_idle: ir=%h cnt=%0d busy=%b valid=%b, required 1234 2 0 0",
               ir, fetch_count, busy, instr_valid);
    end
  endtask

  task automatic test_flush();
    fetch_start = 1; pc = 16'h0020;
    tick();
    fetch_start = 0;
    flush = 1; bus.mem_ack = 1; bus.mem_rdata = 16'hBEEF;   // flush beats ack
    tick();
    flush = 0; bus.mem_rdata = 16'hCAFE;                   // late ack in IDLE
    tick();
    bus.mem_ack = 0;
    tests++;
    if (busy !== 0 || bus.mem_req !== 0 || ir !== 16'h1234 || instr_valid !== 0 || fetch_count !== 16'd2) begin
      fails++;
      $display("FAIL flush_req: busy=%b req=%b ir=%h valid=%b cnt=%0d, required 0 0 1234 0 2",
               busy, bus.mem_req, ir, instr_valid, fetch_count);
    end
    fetch_start = 1; pc = 16'h0030;
    tick();
    fetch_start = 0; bus.mem_ack = 1; bus.mem_rdata = 16'h5A5A;
    tick();
    bus.mem_ack = 0; flush = 1;
    tick();
    flush = 0;
    tests++;
    if (busy !== 0 || instr_valid !== 0 || ir !== 16'h5A5A || fetch_count !== 16'd3) begin
      fails++;
      $display("FAIL flush_hold: busy=%b valid=%b ir=%h cnt=%0d, required 0 0 5a5a 3",
               busy, instr_valid, ir, fetch_count);
    end
  endtask

  task automatic test_reset_mid_req();
    fetch_start = 1; pc = 16'h0050;
    tick();
    fetch_start = 0;
    rst_n = 0;
    #1;
    tests++;
    if (bus.mem_req !== 0 || busy !== 0) begin
      fails++;
      $display("FAIL reset_async: req=%b busy=%b, required 0 0", bus.mem_req, busy);
    end
    bus.mem_ack = 1; bus.mem_rdata = 16'h7777;
    tick();
    bus.mem_ack = 0;
    rst_n = 1;
    tick();
    tests++;
    if (ir !== 0 || fetch_count !== 0 || busy !== 0 || bus.mem_addr !== 0) begin
      fails++;
      $display("FAIL reset_release: ir=%h cnt=%0d busy=%b addr=%h, required 0 0 0 0",
               ir, fetch_count, busy, bus.mem_addr);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    fetch_start = 1; pc = 16'h0060;
    tick();
    fetch_start = 0;
`ifdef FETCH_TIMEOUT_EN
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      if (bus.mem_req !== 1 || fetch_err !== 0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL timeout_early: %0d cycles with req!=1 or err!=0 before limit, required 0", bad);
    end
    tick();
    tests++;
    if (fetch_err !== 1 || bus.mem_req !== 0 || busy !== 0 || fetch_count !== 16'd0) begin
      fails++;
      $display("FAIL timeout_abort: err=%b req=%b busy=%b cnt=%0d, required 1 0 0 0",
               fetch_err, bus.mem_req, busy, fetch_count);
    end
    tick();
    tests++;
    if (fetch_err !== 0) begin
      fails++;
      $display("FAIL timeout_pulse: err=%b, required 0", fetch_err);
    end
`else
    for (int k = 0; k < 45; k++) begin
      tick();
      if (bus.mem_req !== 1 || fetch_err !== 0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL no_timeout: %0d cycles with req!=1 or err!=0, required 0", bad);
    end
    flush = 1;
    tick();
    flush = 0;
`endif
  endtask

  // Model: a request is either outstanding, or a word is held, or neither.
  task automatic test_random();
    bit          waiting = 0, holding = 0, err = 0;
    int          age = 0, bad = 0;
    logic [15:0] mir = '0, maddr = '0, mcnt = '0;
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int c = 0; c < 400; c++) begin
      fetch_start   = ($urandom_range(0, 9) < 4);
      instr_consume = ($urandom_range(0, 9) < 3);
      flush         = ($urandom_range(0, 19) == 0);
      bus.mem_ack   = ($urandom_range(0, 9) < (c < 200 ? 3 : 1));
      pc            = 16'($urandom);
      bus.mem_rdata = 16'($urandom);
      err = 0;
      if (flush) begin
        waiting = 0; holding = 0;
      end else if (waiting) begin
        if (bus.mem_ack) begin
          mir = bus.mem_rdata; mcnt++; waiting = 0; holding = 1;
        end else begin
          age++;
`ifdef FETCH_TIMEOUT_EN
          if (age == TIMEOUT) begin waiting = 0; err = 1; end
`endif
        end
      end else if (holding) begin
        if (instr_consume) begin
          holding = 0;
          if (fetch_start) begin waiting = 1; maddr = pc; age = 0; end
        end
      end else if (fetch_start) begin
        waiting = 1; maddr = pc; age = 0;
      end
      tick();
      tests++;
      if (bus.mem_req !== waiting || instr_valid !== holding || busy !== (waiting | holding) ||
          ir !== mir || fetch_count !== mcnt || fetch_err !== err ||
          (waiting && bus.mem_addr !== maddr) ||
          {opcode, m, rd_f, rs1_f, imm_f} !== mir) begin
        fails++;
        bad++;
        if (bad <= 5)
          $display("FAIL random cyc %0d: req=%b valid=%b ir=%h addr=%h cnt=%h err=%b, required %b %b %h %h %h %b",
                   c, bus.mem_req, instr_valid, ir, bus.mem_addr, fetch_count, fetch_err,
                   waiting, holding, mir, maddr, mcnt, err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_spurious_ack();
    test_flush();
    test_reset_mid_req();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_reg.md
Name: instr_fetch_reg

Overview:
- Instruction-fetch handshake controller and instruction register for the multicycle core.
- Issues a request to instruction memory on command from the control unit and captures the returned word.
- Holds the word stable for the whole multicycle execution of the instruction.
- Presents the split I-type fields (opcode, m, rd, rs1, imm) that feed the I-type to R-type field remapper and the decoder directly downstream.

Parameters:
- IW, 16, instruction word width; field positions below are fixed for IW=16.
- AW, 16, instruction address width.
- TIMEOUT, 15, cycles allowed in REQ before an abort; used only when FETCH_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_start  input  1  control unit requests a fetch at pc.
- pc  input  AW  fetch address, sampled with fetch_start.
- instr_consume  input  1  control unit has finished with the held instruction.
- flush  input  1  synchronous abort; discards any fetch in flight and the held instruction.
- mem_req  output  1  request to instruction memory.
- mem_addr  output  AW  registered fetch address.
- mem_ack  input  1  memory data valid, one-cycle pulse.
- mem_rdata  input  IW  instruction word.
- ir  output  IW  instruction register.
- instr_valid  output  1  ir holds a valid, unconsumed instruction.
- busy  output  1  state is not IDLE.
- opcode  output  4  ir[15:12].
- m  output  1  ir[11].
- rd_f  output  3  ir[10:8].
- rs1_f  output  3  ir[7:5].
- imm_f  output  5  ir[4:0].
- fetch_count  output  16  count of completed fetches; wraps 0xFFFF to 0x0000.
- fetch_err  output  1  timeout abort pulse.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; mem_req=0; mem_addr=0; ir=0; instr_valid=0; fetch_count=0; fetch_err=0; timeout counter=0. All field outputs are therefore 0.
- Field outputs are pure combinational slices of ir. They change only when ir is loaded.
- IDLE:
  - mem_req=0.
  - fetch_start=1: mem_addr<=pc, mem_req<=1, go to REQ. The request is visible one cycle after fetch_start.
- REQ:
  - mem_req=1 and mem_addr are held stable; fetch_start is ignored.
  - mem_ack=1 sampled: ir<=mem_rdata, mem_req<=0, instr_valid<=1, fetch_count<=fetch_count+1, go to HOLD.
  - Latency: data is on ir one cycle after the ack edge.
- HOLD:
  - ir is stable, instr_valid=1, mem_req=0.
  - instr_consume=1 alone: instr_valid<=0, go to IDLE. ir keeps its last value.
  - instr_consume=1 with fetch_start=1 (back-to-back): instr_valid<=0, mem_addr<=pc, mem_req<=1, go to REQ.
  - fetch_start=1 without instr_consume: ignored.
- mem_ack in IDLE or HOLD is ignored: no ir load, no count change.
- flush=1 in any state:
  - Next state IDLE; mem_req<=0; instr_valid<=0; timeout counter cleared; ir unchanged.
  - flush has priority over mem_ack, fetch_start and instr_consume in the same cycle.
  - An ack arriving after a flush is ignored (IDLE rule).
- busy = (state != IDLE).
- fetch_count increments only on an accepted ack; 16-bit wrap, no saturation.
- Reset asserted mid-request: mem_req drops immediately (asynchronous); no capture takes place.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A 5-bit counter clears on entry to REQ and increments on each REQ cycle without an ack.
  - When the counter reaches TIMEOUT with no ack: fetch_err=1 for exactly one cycle, mem_req<=0, state to IDLE. ir, instr_valid and fetch_count are unchanged.
  - An ack in the same cycle the counter reaches TIMEOUT wins: normal capture, no error.
- Undefined: fetch_err is tied 0, no counter is synthesised, and REQ waits indefinitely.

Test Plan:
- Reset, then fetch_start=1, pc=0x0010 -> next cycle mem_req=1, mem_addr=0x0010, busy=1. Ack with rdata=0xA9A5 -> next cycle ir=0xA9A5, opcode=0xA, m=1, rd_f=1, rs1_f=5, imm_f=5, instr_valid=1, fetch_count=1.
- In HOLD assert instr_consume and fetch_start (pc=0x0012) together -> instr_valid=0, mem_req=1 next cycle, mem_addr=0x0012. Ack with 0x1234 -> ir=0x1234, fetch_count=2.
- Spurious mem_ack in IDLE and in HOLD with rdata=0xFFFF -> ir unchanged, fetch_count unchanged.
- flush during REQ, then mem_ack one cycle later -> state IDLE, mem_req=0, ir keeps its old value, instr_valid=0.
- rst_n low mid-REQ -> mem_req=0 immediately; after release ir=0, fetch_count=0, busy=0.
- FETCH_TIMEOUT_EN defined, TIMEOUT=15, no ack -> fetch_err pulses once 15 cycles after entering REQ, mem_req=0, fetch_count unchanged. Macro undefined -> mem_req stays 1 for 40+ cycles with fetch_err=0.
